// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two valid/ready requesters,
// with a one-deep registered response slot per requester and a saturating conflict counter.
module alu_share_arbiter #(
    parameter int unsigned RR_INIT    = 0,
    parameter int unsigned CONF_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [31:0]           req_a0,
    input  logic [31:0]           req_a1,
    input  logic [31:0]           req_b0,
    input  logic [31:0]           req_b1,
    input  logic [3:0]            req_ctrl0,
    input  logic [3:0]            req_ctrl1,
    output logic [1:0]            rsp_valid,
    input  logic [1:0]            rsp_ready,
    output logic [31:0]           rsp_result0,
    output logic [31:0]           rsp_result1,
    output logic [1:0]            rsp_zero,
    output logic [CONF_CNT_W-1:0] conflict_cnt
);

    localparam logic PrioInit = RR_INIT[0];

    logic                  prio_q, prio_d;
    logic [1:0]            rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_result0_q, rsp_result0_d;
    logic [31:0]           rsp_result1_q, rsp_result1_d;
    logic [1:0]            rsp_zero_q, rsp_zero_d;
    logic [CONF_CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;

    logic [1:0]  slot_free;
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic        sel;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero_flag;

    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign eligible  = req_valid & slot_free;

    // No handshake may complete while reset is held.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            if (eligible == 2'b11) begin
                grant = prio_q ? 2'b10 : 2'b01;
            end else begin
                grant = eligible;
            end
        end
    end

    assign req_ready = grant;

    // With no grant the ALU still sees the priority holder's operands; result is dropped.
    assign sel      = grant[1] | ((grant == 2'b00) & prio_q);
    assign alu_a    = sel ? req_a1 : req_a0;
    assign alu_b    = sel ? req_b1 : req_b0;
    assign alu_ctrl = sel ? req_ctrl1 : req_ctrl0;

    always_comb begin
        alu_result = 32'd0;
        unique case (alu_ctrl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0110: alu_result = alu_a - alu_b;
            4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_result = ~(alu_a | alu_b);
            default: alu_result = 32'd0;
        endcase
    end

    assign zero_flag = (alu_result == 32'd0);

    always_comb begin
        prio_d         = prio_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_result0_d  = rsp_result0_q;
        rsp_result1_d  = rsp_result1_q;
        rsp_zero_d     = rsp_zero_q;
        conflict_cnt_d = conflict_cnt_q;

        if (grant[0]) begin
            rsp_result0_d  = alu_result;
            rsp_zero_d[0]  = zero_flag;
            rsp_valid_d[0] = 1'b1;
        end else if (rsp_ready[0]) begin
            rsp_valid_d[0] = 1'b0;
        end

        if (grant[1]) begin
            rsp_result1_d  = alu_result;
            rsp_zero_d[1]  = zero_flag;
            rsp_valid_d[1] = 1'b1;
        end else if (rsp_ready[1]) begin
            rsp_valid_d[1] = 1'b0;
        end

        if (grant != 2'b00) begin
            prio_d = ~grant[1];
        end

        if ((eligible == 2'b11) && (conflict_cnt_q != {CONF_CNT_W{1'b1}})) begin
            conflict_cnt_d = conflict_cnt_q + CONF_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q         <= PrioInit;
            rsp_valid_q    <= 2'b00;
            rsp_result0_q  <= 32'd0;
            rsp_result1_q  <= 32'd0;
            rsp_zero_q     <= 2'b00;
            conflict_cnt_q <= '0;
        end else begin
            prio_q         <= prio_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_result0_q  <= rsp_result0_d;
            rsp_result1_q  <= rsp_result1_d;
            rsp_zero_q     <= rsp_zero_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_result0  = rsp_result0_q;
    assign rsp_result1  = rsp_result1_q;
    assign rsp_zero     = rsp_zero_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a second narrow-counter instance shares stimulus.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [3:0]  req_ctrl0, req_ctrl1;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_result0, rsp_result1;
    logic [1:0]  rsp_zero;
    logic [15:0] conflict_cnt;

    logic [1:0]  w2_req_ready;
    logic [1:0]  w2_rsp_valid;
    logic [31:0] w2_rsp_result0, w2_rsp_result1;
    logic [1:0]  w2_rsp_zero;
    logic [1:0]  w2_conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] cc_snap;

    always #5 clk = ~clk;

    alu_share_arbiter #(.RR_INIT(0), .CONF_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result0(rsp_result0), .rsp_result1(rsp_result1),
        .rsp_zero(rsp_zero), .conflict_cnt(conflict_cnt)
    );

    alu_share_arbiter #(.RR_INIT(0), .CONF_CNT_W(2)) dut_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(w2_req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_ctrl0(req_ctrl0), .req_ctrl1(req_ctrl1), .rsp_valid(w2_rsp_valid),
        .rsp_ready(rsp_ready), .rsp_result0(w2_rsp_result0), .rsp_result1(w2_rsp_result1),
        .rsp_zero(w2_rsp_zero), .conflict_cnt(w2_conflict_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        req_a0 = 0; req_b0 = 0; req_a1 = 0; req_b1 = 0;
        req_ctrl0 = 4'b0010; req_ctrl1 = 4'b0010;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_result0", rsp_result0, 32'd0);
        check("rst_result1", rsp_result1, 32'd0);
        check("rst_zero", 32'(rsp_zero), 32'd0);
        check("rst_conflict", 32'(conflict_cnt), 32'd0);

        // Single ADD from requester 0.
        req_valid = 2'b01; req_a0 = 5; req_b0 = 7; req_ctrl0 = 4'b0010;
        #1;
        check("t1_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 2'b00;
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 32'd1);
        check("t1_result0", rsp_result0, 32'd12);
        check("t1_zero", 32'(rsp_zero), 32'd0);
        rsp_ready = 2'b11;
        step();
        check("t1_drained", 32'(rsp_valid), 32'd0);

        // Re-reset so priority starts at RR_INIT for the alternation test.
        reset = 1'b1;
        step();
        reset = 1'b0;

        // Both requesting every cycle, both draining.
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a0 = 1; req_b0 = 2; req_ctrl0 = 4'b0010;
        req_a1 = 10; req_b1 = 3; req_ctrl1 = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t2_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            check("t2_conflict", 32'(conflict_cnt), 32'(i + 1));
            if (i == 0) check("t2_result0", rsp_result0, 32'd3);
            if (i == 1) check("t2_result1", rsp_result1, 32'd7);
        end
        req_valid = 2'b00;
        step();
        check("t2_drained", 32'(rsp_valid), 32'd0);

        // Requester 1 SUB to zero, then held un-drained.
        rsp_ready = 2'b01;
        req_valid = 2'b10; req_a1 = 9; req_b1 = 9; req_ctrl1 = 4'b0110;
        #1;
        check("t3_grant1", 32'(req_ready), 32'd2);
        step();
        check("t3_valid1", 32'(rsp_valid[1]), 32'd1);
        check("t3_result1", rsp_result1, 32'd0);
        check("t3_zero1", 32'(rsp_zero[1]), 32'd1);
        req_valid = 2'b11; req_a1 = 4; req_b1 = 1;
        req_b0 = 100; req_ctrl0 = 4'b0010;
        cc_snap = conflict_cnt;
        for (int i = 0; i < 3; i++) begin
            req_a0 = 32'(i);
            #1;
            check("t3_grant0_only", 32'(req_ready), 32'd1);
            step();
            check("t3_hold_result1", rsp_result1, 32'd0);
            check("t3_hold_zero1", 32'(rsp_zero[1]), 32'd1);
            check("t3_hold_valid", 32'(rsp_valid), 32'd3);
            check("t3_result0", rsp_result0, 32'(100 + i));
            check("t3_conflict_flat", 32'(conflict_cnt), 32'(cc_snap));
        end

        // Slot 0 full, drained and refilled in the same cycle.
        req_valid = 2'b01; req_a0 = 20; req_b0 = 22;
        #1;
        check("t4_grant", 32'(req_ready), 32'd1);
        step();
        check("t4_valid", 32'(rsp_valid), 32'd3);
        check("t4_result0", rsp_result0, 32'd42);

        // Reset with both slots full.
        reset = 1'b1; req_valid = 2'b11; rsp_ready = 2'b00;
        #1;
        check("t6_no_grant_in_reset", 32'(req_ready), 32'd0);
        step();
        reset = 1'b0; req_valid = 2'b00;
        #1;
        check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
        check("t6_result0", rsp_result0, 32'd0);
        check("t6_result1", rsp_result1, 32'd0);
        check("t6_conflict", 32'(conflict_cnt), 32'd0);
        check("t6_w2_conflict", 32'(w2_conflict_cnt), 32'd0);

        // Five conflicts: narrow counter saturates, first grant goes to RR_INIT.
        req_valid = 2'b11; rsp_ready = 2'b11;
        req_a0 = 32'h0f; req_b0 = 32'h3c; req_ctrl0 = 4'b0000;
        req_a1 = 1; req_b1 = 2; req_ctrl1 = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t5_grant", 32'(req_ready), (i % 2 == 0) ? 32'd1 : 32'd2);
            step();
            if (i == 0) check("t5_and", rsp_result0, 32'h0c);
            if (i == 1) check("t5_slt", rsp_result1, 32'd1);
        end
        check("t5_w2_saturated", 32'(w2_conflict_cnt), 32'd3);
        check("t5_conflict16", 32'(conflict_cnt), 32'd5);

        // NOR from requester 0 alone.
        req_valid = 2'b01; req_a0 = 32'hffff0000; req_b0 = 32'h0000ff00; req_ctrl0 = 4'b1100;
        step();
        check("t7_nor", rsp_result0, 32'h000000ff);
        req_valid = 2'b00;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
